// File: rtl/qbus_pkg.sv
// Shared constants for the VM1 bus responder: FSM encoding, transfer direction
// and the default decode windows for on-board RAM and the peripheral register page.
package qbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SKIP  = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_READ  = 3'd4,
        S_REPLY = 3'd5
    } qstate_t;

    localparam logic DIR_RD = 1'b1;
    localparam logic DIR_WR = 1'b0;

    localparam logic [15:0] RAM_BASE = 16'o100000;
    localparam logic [15:0] RAM_MASK = 16'o140000;
    localparam logic [15:0] REG_BASE = 16'o177600;
    localparam logic [15:0] REG_MASK = 16'o177700;

    // Byte lanes stay in place: an odd byte lives in [15:8], an even byte in [7:0].
    function automatic logic [1:0] write_be(input logic wtbt, input logic odd);
        if (!wtbt)
            return 2'b11;
        return odd ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/qbus_slave.sv
// VM1 bus responder: claims an address window, turns a SYNC/DIN/DOUT cycle into
// one-cycle local memory strobes and answers with RPLY after a fixed wait.
module qbus_slave
    import qbus_pkg::*;
#(
    parameter logic [15:0] BASE        = RAM_BASE,
    parameter logic [15:0] MASK        = RAM_MASK,
    parameter int          WAIT_STATES = 0,
    parameter int          AW          = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          SYNC,
    input  logic          DIN,
    input  logic          DOUT,
    input  logic          WTBT,
    input  logic [15:0]   addr_i,
    input  logic [15:0]   data_i,
    output logic          RPLY,
    output logic [15:0]   data_o,
    output logic          data_oe,
    output logic          sel,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [1:0]    mem_be,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata
);

    // The request edge itself counts as the first wait step, so the counter
    // is loaded one short and a zero-wait slave strobes straight out of ARM.
    localparam bit       WS_ZERO = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD = WS_ZERO ? 4'd0 : 4'(WAIT_STATES - 1);

    qstate_t         r_state, w_state;
    logic            r_sync_q;
    logic [3:0]      r_cnt, w_cnt;
    logic            r_dir, w_dir;
    logic            r_odd, w_odd;
    logic            r_wtbt, w_wtbt;
    logic            r_rply, w_rply;
    logic            r_oe, w_oe;
    logic            r_sel, w_sel;
    logic            r_rd, w_rd;
    logic            r_wr, w_wr;
    logic [1:0]      r_be, w_be;
    logic [15:0]     r_data_o, w_data_o;
    logic [AW-1:0]   r_addr, w_addr;
    logic [15:0]     r_wdata, w_wdata;
    logic            w_start;
    logic            w_match;
    logic            w_fire;

    assign w_start = SYNC & ~r_sync_q;
    assign w_match = ((addr_i & MASK) == BASE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sync_q <= 1'b0;
            r_cnt    <= 4'd0;
            r_dir    <= DIR_WR;
            r_odd    <= 1'b0;
            r_wtbt   <= 1'b0;
            r_rply   <= 1'b0;
            r_oe     <= 1'b0;
            r_sel    <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_be     <= 2'b00;
            r_data_o <= 16'd0;
            r_addr   <= '0;
            r_wdata  <= 16'd0;
        end else if (ce) begin
            r_state  <= w_state;
            r_sync_q <= SYNC;
            r_cnt    <= w_cnt;
            r_dir    <= w_dir;
            r_odd    <= w_odd;
            r_wtbt   <= w_wtbt;
            r_rply   <= w_rply;
            r_oe     <= w_oe;
            r_sel    <= w_sel;
            r_rd     <= w_rd;
            r_wr     <= w_wr;
            r_be     <= w_be;
            r_data_o <= w_data_o;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_dir    = r_dir;
        w_odd    = r_odd;
        w_wtbt   = r_wtbt;
        w_rply   = r_rply;
        w_oe     = r_oe;
        w_sel    = r_sel;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_be     = r_be;
        w_data_o = r_data_o;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_fire   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_match) begin
                        w_addr  = addr_i[AW:1];
                        w_odd   = addr_i[0];
                        w_wtbt  = WTBT;
                        w_sel   = 1'b1;
                        w_state = S_ARM;
                    end else begin
                        w_state = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (!SYNC)
                    w_state = S_IDLE;
            end
            S_ARM: begin
                if (!SYNC) begin
                    w_sel   = 1'b0;
                    w_state = S_IDLE;
                end else if (DIN || DOUT) begin
                    w_dir = DIN ? DIR_RD : DIR_WR;
                    if (WS_ZERO) begin
                        w_fire = 1'b1;
                    end else begin
                        w_cnt   = WS_LOAD;
                        w_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!SYNC) begin
                    w_sel   = 1'b0;
                    w_state = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_fire = 1'b1;
                end
            end
            S_READ: begin
                w_data_o = mem_rdata;
                w_oe     = 1'b1;
                w_rply   = 1'b1;
                w_state  = S_REPLY;
            end
            S_REPLY: begin
                if (!DIN && !DOUT) begin
                    w_rply  = 1'b0;
                    w_oe    = 1'b0;
                    w_sel   = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_fire) begin
            if (w_dir == DIR_RD) begin
                w_rd    = 1'b1;
                w_be    = 2'b11;
                w_state = S_READ;
            end else begin
                w_wr    = 1'b1;
                w_wdata = data_i;
                w_be    = write_be(r_wtbt, r_odd);
                w_rply  = 1'b1;
                w_state = S_REPLY;
            end
        end
    end

    assign RPLY      = r_rply;
    assign data_o    = r_data_o;
    assign data_oe   = r_oe;
    assign sel       = r_sel;
    assign mem_addr  = r_addr;
    assign mem_rd    = r_rd & ce;
    assign mem_wr    = r_wr & ce;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_qbus_slave.sv
// Bench for qbus_slave: three responders (0, 3 and 8 wait states) on one bus,
// checked each cycle against a timeline model, plus directed literal cases.
module tb_qbus_slave;

    localparam int NI = 3;
    localparam int WS0 = 0;
    localparam int WS1 = 3;
    localparam int WS2 = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b1;
    logic SYNC = 1'b0, DIN = 1'b0, DOUT = 1'b0, WTBT = 1'b0;
    logic [15:0] addr_i = 16'd0, data_i = 16'd0, mem_rdata = 16'd0;

    logic [NI-1:0]       rply, oe, sel, rd, wr;
    logic [NI-1:0][15:0] dato, wdata;
    logic [NI-1:0][14:0] maddr;
    logic [NI-1:0][1:0]  be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qbus_slave #(.WAIT_STATES(WS0)) u0 (
        .clk(clk), .reset(reset), .ce(ce), .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT),
        .addr_i(addr_i), .data_i(data_i), .RPLY(rply[0]), .data_o(dato[0]), .data_oe(oe[0]),
        .sel(sel[0]), .mem_addr(maddr[0]), .mem_rd(rd[0]), .mem_wr(wr[0]), .mem_be(be[0]),
        .mem_wdata(wdata[0]), .mem_rdata(mem_rdata));
    qbus_slave #(.WAIT_STATES(WS1)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT),
        .addr_i(addr_i), .data_i(data_i), .RPLY(rply[1]), .data_o(dato[1]), .data_oe(oe[1]),
        .sel(sel[1]), .mem_addr(maddr[1]), .mem_rd(rd[1]), .mem_wr(wr[1]), .mem_be(be[1]),
        .mem_wdata(wdata[1]), .mem_rdata(mem_rdata));
    qbus_slave #(.WAIT_STATES(WS2)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT),
        .addr_i(addr_i), .data_i(data_i), .RPLY(rply[2]), .data_o(dato[2]), .data_oe(oe[2]),
        .sel(sel[2]), .mem_addr(maddr[2]), .mem_rd(rd[2]), .mem_wr(wr[2]), .mem_be(be[2]),
        .mem_wdata(wdata[2]), .mem_rdata(mem_rdata));

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: each responder's transaction is tracked as edges since
    // the claiming edge; the strobe lands W edges after the request is seen.
    int ws[NI] = '{WS0, WS1, WS2};
    logic m_syncq;
    bit   m_act[NI], m_skip[NI], m_rdp[NI], m_rep[NI], m_isrd[NI], m_wtbt[NI], m_odd[NI];
    int   m_t[NI], m_treq[NI];
    logic [NI-1:0]       e_rply, e_oe, e_sel, e_rd, e_wr;
    logic [NI-1:0][15:0] e_dato, e_wdata;
    logic [NI-1:0][14:0] e_addr;
    logic [NI-1:0][1:0]  e_be;

    task automatic model_reset();
        m_syncq = 1'b0;
        e_rply = '0; e_oe = '0; e_sel = '0; e_rd = '0; e_wr = '0;
        e_dato = '0; e_wdata = '0; e_addr = '0; e_be = '0;
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 0; m_skip[i] = 0; m_rdp[i] = 0; m_rep[i] = 0;
            m_isrd[i] = 0; m_wtbt[i] = 0; m_odd[i] = 0; m_t[i] = 0; m_treq[i] = -1;
        end
    endtask

    // Applies the bus values that the next rising edge will sample.
    task automatic model_step();
        logic st;
        st = SYNC && !m_syncq;
        for (int i = 0; i < NI; i++) begin
            e_rd[i] = 1'b0;
            e_wr[i] = 1'b0;
            if (m_rep[i]) begin
                if (!DIN && !DOUT) begin
                    m_rep[i] = 0; e_rply[i] = 1'b0; e_oe[i] = 1'b0; e_sel[i] = 1'b0;
                end
            end else if (m_rdp[i]) begin
                m_rdp[i] = 0; m_rep[i] = 1;
                e_dato[i] = mem_rdata; e_oe[i] = 1'b1; e_rply[i] = 1'b1;
            end else if (m_act[i]) begin
                m_t[i]++;
                if (!SYNC) begin
                    m_act[i] = 0; e_sel[i] = 1'b0;
                end else begin
                    if (m_treq[i] < 0 && (DIN || DOUT)) begin
                        m_treq[i] = m_t[i]; m_isrd[i] = DIN;
                    end
                    if (m_treq[i] >= 0 && m_t[i] == m_treq[i] + ws[i]) begin
                        m_act[i] = 0;
                        if (m_isrd[i]) begin
                            e_rd[i] = 1'b1; e_be[i] = 2'b11; m_rdp[i] = 1;
                        end else begin
                            e_wr[i] = 1'b1; e_wdata[i] = data_i; e_rply[i] = 1'b1; m_rep[i] = 1;
                            e_be[i] = m_wtbt[i] ? (m_odd[i] ? 2'b10 : 2'b01) : 2'b11;
                        end
                    end
                end
            end else if (m_skip[i]) begin
                if (!SYNC) m_skip[i] = 0;
            end else if (st) begin
                if ((addr_i & 16'o140000) == 16'o100000) begin
                    m_act[i] = 1; m_t[i] = 0; m_treq[i] = -1;
                    e_addr[i] = addr_i[15:1]; m_odd[i] = addr_i[0]; m_wtbt[i] = WTBT;
                    e_sel[i] = 1'b1;
                end else begin
                    m_skip[i] = 1;
                end
            end
        end
        m_syncq = SYNC;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) begin
                model_reset();
            end else begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("u%0d.RPLY", i), 16'(rply[i]), 16'(e_rply[i]));
                    chk($sformatf("u%0d.data_oe", i), 16'(oe[i]), 16'(e_oe[i]));
                    chk($sformatf("u%0d.sel", i), 16'(sel[i]), 16'(e_sel[i]));
                    chk($sformatf("u%0d.mem_rd", i), 16'(rd[i]), 16'(e_rd[i] & ce));
                    chk($sformatf("u%0d.mem_wr", i), 16'(wr[i]), 16'(e_wr[i] & ce));
                    chk($sformatf("u%0d.mem_be", i), 16'(be[i]), 16'(e_be[i]));
                    chk($sformatf("u%0d.data_o", i), dato[i], e_dato[i]);
                    chk($sformatf("u%0d.mem_addr", i), 16'(maddr[i]), 16'(e_addr[i]));
                    chk($sformatf("u%0d.mem_wdata", i), wdata[i], e_wdata[i]);
                end
                if (ce) model_step();
            end
        end
    end

    bit ce_tog = 0;
    bit ce_rand = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ce-edge; in toggle mode a frozen clk precedes every active one.
    task automatic cetick();
        if (ce_tog) begin
            ce = 1'b0;
            tick();
            ce = 1'b1;
        end
        tick();
    endtask

    task automatic idle(input int n);
        SYNC = 1'b0; DIN = 1'b0; DOUT = 1'b0; WTBT = 1'b0;
        repeat (n) tick();
    endtask

    task automatic directed_read();
        SYNC = 1'b1; DIN = 1'b1; addr_i = 16'o100004; mem_rdata = 16'o123456;
        cetick();
        chk("rd.e1.sel", 16'(sel[0]), 16'd1);
        chk("rd.e1.mem_rd", 16'(rd[0]), 16'd0);
        cetick();
        chk("rd.e2.mem_rd", 16'(rd[0]), 16'd1);
        chk("rd.e2.mem_addr", 16'(maddr[0]), 16'o40002);
        chk("rd.e2.RPLY", 16'(rply[0]), 16'd0);
        cetick();
        chk("rd.e3.RPLY", 16'(rply[0]), 16'd1);
        chk("rd.e3.data_o", dato[0], 16'o123456);
        chk("rd.e3.data_oe", 16'(oe[0]), 16'd1);
        chk("rd.e3.mem_rd", 16'(rd[0]), 16'd0);
        DIN = 1'b0;
        cetick();
        chk("rd.rel.RPLY", 16'(rply[0]), 16'd0);
        chk("rd.rel.sel", 16'(sel[0]), 16'd0);
        ce = 1'b1;
        idle(20);
    endtask

    initial begin
        addr_i = 16'd0;
        repeat (3) tick();
        chk("rst.RPLY", 16'(rply), 16'd0);
        chk("rst.oe_sel", 16'({oe, sel}), 16'd0);
        chk("rst.rd_wr", 16'({rd, wr}), 16'd0);
        chk("rst.be", 16'(be), 16'd0);
        chk("rst.data_o", dato[0] | dato[1] | dato[2], 16'd0);
        chk("rst.mem_addr", 16'(maddr[0] | maddr[1] | maddr[2]), 16'd0);
        chk("rst.wdata", wdata[0] | wdata[1] | wdata[2], 16'd0);
        reset = 1'b0;
        idle(3);

        directed_read();

        // word write, 3 wait states
        SYNC = 1'b1; DOUT = 1'b1; addr_i = 16'o100010; data_i = 16'hBEEF;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("wr.e%0d.mem_wr", e), 16'(wr[1]), 16'd0);
        end
        tick();
        chk("wr.e5.mem_wr", 16'(wr[1]), 16'd1);
        chk("wr.e5.be", 16'(be[1]), 16'b11);
        chk("wr.e5.wdata", wdata[1], 16'hBEEF);
        chk("wr.e5.RPLY", 16'(rply[1]), 16'd1);
        tick();
        chk("wr.e6.mem_wr", 16'(wr[1]), 16'd0);
        chk("wr.e6.RPLY", 16'(rply[1]), 16'd1);
        DOUT = 1'b0;
        tick();
        chk("wr.rel.RPLY", 16'(rply[1]), 16'd0);
        idle(20);

        // byte writes
        SYNC = 1'b1; DOUT = 1'b1; WTBT = 1'b1; addr_i = 16'o100001; data_i = 16'hAB00;
        tick(); tick();
        chk("bw.odd.mem_wr", 16'(wr[0]), 16'd1);
        chk("bw.odd.be", 16'(be[0]), 16'b10);
        chk("bw.odd.wdata", wdata[0], 16'hAB00);
        idle(20);
        SYNC = 1'b1; DOUT = 1'b1; WTBT = 1'b1; addr_i = 16'o100000; data_i = 16'h00CD;
        tick(); tick();
        chk("bw.even.be", 16'(be[0]), 16'b01);
        chk("bw.even.wdata", wdata[0], 16'h00CD);
        idle(20);

        // unselected address
        SYNC = 1'b1; DIN = 1'b1; addr_i = 16'o040000;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("unsel.outs", 16'({sel, rply, oe, rd}), 16'd0);
        end
        idle(3);
        directed_read();

        // abort a long-wait write, then a complete one
        SYNC = 1'b1; DOUT = 1'b1; addr_i = 16'o100020; data_i = 16'h1234;
        repeat (4) tick();
        SYNC = 1'b0; DOUT = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("abort.wr_rply", 16'({wr[2], rply[2]}), 16'd0);
        end
        SYNC = 1'b1; DOUT = 1'b1; addr_i = 16'o100022; data_i = 16'h5678;
        repeat (9) tick();
        chk("post.e9.mem_wr", 16'(wr[2]), 16'd0);
        tick();
        chk("post.e10.mem_wr", 16'(wr[2]), 16'd1);
        chk("post.e10.RPLY", 16'(rply[2]), 16'd1);
        chk("post.e10.wdata", wdata[2], 16'h5678);
        idle(20);

        // same read latency counted in ce-edges with ce toggling
        ce_tog = 1;
        directed_read();
        ce_tog = 0;

        // reset while replying
        SYNC = 1'b1; DIN = 1'b1; addr_i = 16'o100004; mem_rdata = 16'h0F0F;
        repeat (3) tick();
        chk("rr.RPLY.before", 16'(rply[0]), 16'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        SYNC = 1'b0; DIN = 1'b0;
        #1;
        chk("rr.RPLY.async", 16'(rply), 16'd0);
        chk("rr.sel", 16'(sel), 16'd0);
        repeat (2) tick();
        reset = 1'b0;
        idle(3);
        directed_read();

        // randomized bus traffic
        for (int n = 0; n < 300; n++) begin
            int hold;
            ce_rand = (n >= 150);
            case ($urandom_range(0, 3))
                0, 1: addr_i = 16'o100000 | 16'($urandom_range(0, 16'o37777));
                2:    addr_i = 16'o177600 + 16'($urandom_range(0, 63));
                default: addr_i = 16'($urandom);
            endcase
            WTBT = 1'($urandom);
            SYNC = 1'b1;
            rtick($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) DIN = 1'b1; else DOUT = 1'b1;
            hold = $urandom_range(0, 25);
            if ($urandom_range(0, 9) == 0) begin
                rtick(hold / 4);
                SYNC = 1'b0;
                rtick(1);
                DIN = 1'b0; DOUT = 1'b0;
            end else begin
                rtick(hold);
                DIN = 1'b0; DOUT = 1'b0;
                rtick($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    DIN = 1'b1;
                    rtick($urandom_range(1, 6));
                    DIN = 1'b0;
                end
            end
            SYNC = 1'b0;
            rtick($urandom_range(1, 4));
        end
        ce = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic rtick(input int n);
        for (int k = 0; k < n; k++) begin
            ce = ce_rand ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            data_i = 16'($urandom);
            mem_rdata = 16'($urandom);
            tick();
        end
    endtask

endmodule
